conv_acc_stream: RTL and testbench
==================================

CONV_ACC_STREAM -- requirements
Module: conv_acc_stream

Interface
REQ-001 Parameter DW, default 8: output pixel width, signed; 32 must be divisible by DW.
REQ-002 Parameter ACCW, default 20: partial-sum and accumulator width, signed.
REQ-003 Parameter ROWS, default 3: output rows delivered in parallel per input vector.
REQ-004 Parameter OW, default 48: output columns; multiple of PACK = 32/DW.
REQ-005 Parameter OH, default 48: output rows; multiple of ROWS.
REQ-006 clk  input  1  clock, all logic on rising edge.
REQ-007 rstn  input  1  reset, synchronous, active-low.
REQ-008 i_bias  input  DW  signed bias for the current output channel.
REQ-009 i_bias_valid  input  1  bias load strobe.
REQ-010 i_psum  input  ROWS*ACCW  signed 3x3 partial sums; lane r in bits [(r+1)*ACCW-1 : r*ACCW] is output row base+r.
REQ-011 i_psum_valid  input  1  i_psum qualifier.
REQ-012 o_psum_ready  output  1  block accepts i_psum this cycle.
REQ-013 i_first_ic  input  1  level; current vectors belong to the first input channel.
REQ-014 i_last_ic  input  1  level; current vectors belong to the last input channel.
REQ-015 o_busy  output  1  high whenever state is not IDLE.
REQ-016 m_axis_tvalid/tdata[31:0]/tstrb[3:0]/tlast/tready: AXI4-Stream master, tready is the only input.

Function
REQ-017 States: IDLE, ACCUM, DRAIN; reset enters IDLE.
REQ-018 IDLE->ACCUM on the first accepted psum vector; ACCUM->DRAIN after the vector at row group OH/ROWS-1, column OW-1 is accepted with i_last_ic=1; DRAIN->IDLE on the handshake of the tlast beat.
REQ-019 Handshake: a vector is accepted when i_psum_valid && o_psum_ready; o_psum_ready is 1 in IDLE and ACCUM and 0 in DRAIN.
REQ-020 Vector order is raster: column 0..OW-1 within a row group, then the next row group of ROWS rows; the column and row-group counters wrap to 0 after the last vector of each channel.
REQ-021 Storage: ROWS banks, each (OH/ROWS)*OW words of ACCW bits; lane r writes bank r at address group*OW + column, all lanes in the same cycle.
REQ-022 Accumulation: with i_first_ic=1 the stored value is i_psum lane; otherwise it is the stored word plus the lane, computed as read-modify-write.
REQ-023 Sums saturate to the signed ACCW range.
REQ-024 Back-to-back accepted vectors shall be sustained at 1 vector per cycle; a write-to-read bypass covers any RMW hazard.
REQ-025 Bias is latched on i_bias_valid only in IDLE and ignored in other states.
REQ-026 Bias is sign-extended to ACCW before use.
REQ-027 DRAIN output pixel = accumulator + bias, with ReLU applied (negative becomes 0), then saturated to [0, 2^(DW-1)-1].
REQ-028 DRAIN emits pixels in raster order (row 0..OH-1, column 0..OW-1).
REQ-029 Each beat carries PACK pixels; the lowest column is in tdata[DW-1:0].
REQ-030 tstrb is constantly 4'b1111.
REQ-031 Beat count per DRAIN is OH*OW/PACK.
REQ-032 tlast is 1 only on the final beat.
REQ-033 AXIS rules: tvalid stays asserted and tdata/tlast stay stable while tready=0; the next beat advances only on tvalid && tready.
REQ-034 The first tvalid is asserted no more than 3 cycles after entering DRAIN.
REQ-035 With tready held high, throughput is 1 beat per cycle.
REQ-036 i_first_ic and i_last_ic both high in one vector means single-channel operation: the stored value is the lane, and the transition rule of REQ-018 applies.
REQ-037 i_psum_valid in DRAIN is ignored; no write or counter change occurs.

Reset
REQ-038 Reset values: tvalid=0, tlast=0, tdata=0, o_busy=0, o_psum_ready=1.
REQ-039 Reset clears all counters and the bias register to 0; bank contents are not cleared.
REQ-040 rstn low mid-ACCUM or mid-DRAIN aborts within one cycle; the output stream is truncated without tlast, and the next run restarts at row 0, column 0.

Verification
REQ-041 Bench config DW=8, ACCW=20, ROWS=3, OW=4, OH=3, bias=0; one channel (first=last=1) with every lane=5 -> 3 beats of 0x05050505, tlast on beat 3 only.
REQ-042 Two channels, lane values 100 then 30, bias=-10 -> every pixel 120 (0x78787878).
REQ-043 Single channel, lanes=-50, bias=+20 -> all pixels 0 (ReLU).
REQ-044 Single channel, lanes=+300 -> all pixels 127; lanes=524287 accumulated over 2 channels -> accumulator saturates at 524287, pixel 127.
REQ-045 tready toggled 1,0,0,1 during DRAIN -> tdata/tlast held during stall cycles, no beat lost or duplicated, o_psum_ready=0 throughout DRAIN.
REQ-046 rstn asserted after beat 1 of DRAIN -> tvalid=0 next cycle, o_busy=0; a following run reproduces the REQ-041 output exactly.

Source files
------------

// File: rtl/conv_acc_stream.sv
// Accumulates ROWS-wide 3x3 partial-sum vectors over input channels into on-chip banks,
// then streams bias+ReLU+saturated pixels out over AXI4-Stream in raster order.
module conv_acc_stream #(
  parameter int DW   = 8,
  parameter int ACCW = 20,
  parameter int ROWS = 3,
  parameter int OW   = 48,
  parameter int OH   = 48
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DW-1:0]        i_bias,
  input  logic                 i_bias_valid,
  input  logic [ROWS*ACCW-1:0] i_psum,
  input  logic                 i_psum_valid,
  output logic                 o_psum_ready,
  input  logic                 i_first_ic,
  input  logic                 i_last_ic,
  output logic                 o_busy,
  output logic                 m_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tstrb,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready
);

  localparam int PACK  = 32 / DW;
  localparam int NGRP  = OH / ROWS;
  localparam int DEPTH = NGRP * OW;
  localparam int BPR   = OW / PACK;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (OW > 1) ? $clog2(OW) : 1;
  localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int BKW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BCW   = (BPR > 1) ? $clog2(BPR) : 1;

  localparam logic [CW-1:0]  COL_LAST  = CW'(OW - 1);
  localparam logic [GW-1:0]  GRP_LAST  = GW'(NGRP - 1);
  localparam logic [BKW-1:0] BANK_LAST = BKW'(ROWS - 1);
  localparam logic [BCW-1:0] BCOL_LAST = BCW'(BPR - 1);

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW:0]   PIX_MAX = (ACCW+1)'((1 << (DW - 1)) - 1);

  function automatic logic signed [ACCW:0] add_ext(input logic signed [ACCW-1:0] a,
                                                   input logic signed [ACCW-1:0] b);
    return {a[ACCW-1], a} + {b[ACCW-1], b};
  endfunction

  function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] v);
    if (v[ACCW] != v[ACCW-1]) return v[ACCW] ? ACC_MIN : ACC_MAX;
    return v[ACCW-1:0];
  endfunction

  function automatic logic [DW-1:0] relu_sat(input logic signed [ACCW:0] v);
    if (v[ACCW]) return '0;
    if (v > PIX_MAX) return PIX_MAX[DW-1:0];
    return v[DW-1:0];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                    r_state, w_state_nxt;
  logic signed [ACCW-1:0]    r_mem [ROWS][DEPTH];
  logic signed [DW-1:0]      r_bias;
  logic signed [ACCW-1:0]    w_bias_ext;
  logic [CW-1:0]             r_col;
  logic [GW-1:0]             r_grp;
  logic [AW-1:0]             w_acc_addr;
  logic                      w_acc, w_last_pos, w_byp;

  logic                      r_vld_p0;
  logic                      r_first_p0;
  logic [AW-1:0]             r_addr_p0;
  logic [ROWS*ACCW-1:0]      r_lane_p0;
  logic [ROWS*ACCW-1:0]      r_rd_p0;
  logic [ROWS*ACCW-1:0]      w_wr_data;

  logic [BKW-1:0]            r_rd_bank;
  logic [GW-1:0]             r_rd_grp;
  logic [BCW-1:0]            r_rd_bcol;
  logic                      r_ld_done;
  logic                      r_tvalid, r_tlast;
  logic [31:0]               r_tdata;
  logic [31:0]               w_beat;
  logic                      w_ld, w_ld_last, w_hs;

  assign o_busy        = (r_state != S_IDLE);
  assign o_psum_ready  = (r_state != S_DRAIN);
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tstrb  = 4'b1111;

  assign w_acc      = i_psum_valid && o_psum_ready;
  assign w_last_pos = (r_col == COL_LAST) && (r_grp == GRP_LAST);
  assign w_acc_addr = AW'(int'(r_grp) * OW + int'(r_col));
  assign w_bias_ext = ACCW'(r_bias);
  assign w_hs       = r_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: if (w_acc) w_state_nxt = (w_last_pos && i_last_ic) ? S_DRAIN : S_ACCUM;
      S_DRAIN:         if (w_hs && r_tlast) w_state_nxt = S_IDLE;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 boundary: accepted vector captured together with the bank read
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld_p0 <= 1'b0;
      r_col    <= '0;
      r_grp    <= '0;
      r_bias   <= '0;
    end else begin
      r_vld_p0 <= w_acc;
      if (r_state == S_IDLE && i_bias_valid) r_bias <= i_bias;
      if (w_acc) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_grp <= (r_grp == GRP_LAST) ? '0 : r_grp + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // A read that hits the word being written this cycle takes the new value instead
  assign w_byp = r_vld_p0 && (r_addr_p0 == w_acc_addr);

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lane_p0  <= i_psum;
      r_addr_p0  <= w_acc_addr;
      r_first_p0 <= i_first_ic;
      for (int r = 0; r < ROWS; r++)
        r_rd_p0[r*ACCW +: ACCW] <= w_byp ? w_wr_data[r*ACCW +: ACCW] : r_mem[r][w_acc_addr];
    end
    if (r_vld_p0)
      for (int r = 0; r < ROWS; r++)
        r_mem[r][r_addr_p0] <= w_wr_data[r*ACCW +: ACCW];
  end

  always_comb begin
    w_wr_data = '0;
    for (int r = 0; r < ROWS; r++)
      w_wr_data[r*ACCW +: ACCW] = r_first_p0 ? r_lane_p0[r*ACCW +: ACCW]
                                 : sat_acc(add_ext(r_rd_p0[r*ACCW +: ACCW], r_lane_p0[r*ACCW +: ACCW]));
  end

  // Drain waits one cycle after the last write so the final vector is in the banks
  assign w_ld      = (r_state == S_DRAIN) && !r_vld_p0 && !r_ld_done && (!r_tvalid || m_axis_tready);
  assign w_ld_last = (r_rd_bank == BANK_LAST) && (r_rd_grp == GRP_LAST) && (r_rd_bcol == BCOL_LAST);

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < PACK; k++)
      w_beat[k*DW +: DW] = relu_sat(add_ext(
        r_mem[r_rd_bank][AW'(int'(r_rd_grp) * OW + int'(r_rd_bcol) * PACK + k)], w_bias_ext));
  end

  // Output register boundary: holds the beat stable until the sink takes it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
      r_ld_done <= 1'b0;
      r_rd_bank <= '0;
      r_rd_grp  <= '0;
      r_rd_bcol <= '0;
    end else begin
      if (w_ld) begin
        r_tvalid  <= 1'b1;
        r_tdata   <= w_beat;
        r_tlast   <= w_ld_last;
        r_ld_done <= w_ld_last;
        if (r_rd_bcol == BCOL_LAST) begin
          r_rd_bcol <= '0;
          if (r_rd_bank == BANK_LAST) begin
            r_rd_bank <= '0;
            r_rd_grp  <= (r_rd_grp == GRP_LAST) ? '0 : r_rd_grp + 1'b1;
          end else begin
            r_rd_bank <= r_rd_bank + 1'b1;
          end
        end else begin
          r_rd_bcol <= r_rd_bcol + 1'b1;
        end
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_hs && r_tlast) r_ld_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_acc_stream.sv
// Directed bench for conv_acc_stream: small 4x3 image, bias/ReLU/saturation,
// back-pressure, ignored psum in drain and abort by reset.
module tb_conv_acc_stream;
  localparam int DW = 8, ACCW = 20, ROWS = 3, OW = 4, OH = 3;
  localparam int PACK = 32 / DW, NG = OH / ROWS;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [DW-1:0]        i_bias = '0;
  logic                 i_bias_valid = 1'b0;
  logic [ROWS*ACCW-1:0] i_psum = '0;
  logic                 i_psum_valid = 1'b0;
  logic                 o_psum_ready;
  logic                 i_first_ic = 1'b0;
  logic                 i_last_ic = 1'b0;
  logic                 o_busy;
  logic                 m_axis_tvalid;
  logic [31:0]          m_axis_tdata;
  logic [3:0]           m_axis_tstrb;
  logic                 m_axis_tlast;
  logic                 m_axis_tready = 1'b1;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];
  int acc_m [OH][OW];
  logic [3:0] pat = 4'b1001;

  conv_acc_stream #(.DW(DW), .ACCW(ACCW), .ROWS(ROWS), .OW(OW), .OH(OH)) dut (
    .clk(clk), .rstn(rstn), .i_bias(i_bias), .i_bias_valid(i_bias_valid),
    .i_psum(i_psum), .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
    .i_first_ic(i_first_ic), .i_last_ic(i_last_ic), .o_busy(o_busy),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int sat_m(input int v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic load_bias(input int b);
    @(negedge clk);
    i_bias = DW'(b);
    i_bias_valid = 1'b1;
    @(negedge clk);
    i_bias_valid = 1'b0;
  endtask

  // One input channel in raster order; lane value = base + step*(pixel index)
  task automatic run_channel(input int base, input int step, input bit first, input bit last);
    int v;
    for (int g = 0; g < NG; g++) begin
      for (int c = 0; c < OW; c++) begin
        @(negedge clk);
        chk("psum_ready", o_psum_ready, 1);
        for (int r = 0; r < ROWS; r++) begin
          v = base + step * ((g * ROWS + r) * OW + c);
          i_psum[r*ACCW +: ACCW] = ACCW'(v);
          acc_m[g*ROWS+r][c] = first ? v : sat_m(acc_m[g*ROWS+r][c] + v);
        end
        i_psum_valid = 1'b1;
        i_first_ic = first;
        i_last_ic = last;
      end
    end
    @(negedge clk);
    i_psum_valid = 1'b0;
  endtask

  task automatic push_expected(input int bias);
    logic [31:0] word;
    int p;
    for (int y = 0; y < OH; y++) begin
      for (int b = 0; b < OW / PACK; b++) begin
        word = '0;
        for (int k = 0; k < PACK; k++) begin
          p = acc_m[y][b*PACK+k] + bias;
          if (p < 0) p = 0;
          if (p > 127) p = 127;
          word[k*DW +: DW] = DW'(p);
        end
        exp_q.push_back({(y == OH - 1 && b == OW / PACK - 1), word});
      end
    end
  endtask

  task automatic drain(input bit use_pat, input int stop_after, input bit garbage);
    int waited = 0, got = 0, cyc = 0;
    bit seen = 0, stalled = 0;
    logic [32:0] hold = '0;
    logic [32:0] expv;
    while (exp_q.size() > 0 && waited < 100) begin
      @(negedge clk);
      waited++;
      if (stalled) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_hold", {m_axis_tlast, m_axis_tdata}, hold);
      end
      stalled = 0;
      chk("drain_ready", o_psum_ready, 0);
      if (garbage) begin
        i_psum_valid = 1'b1;
        i_psum = {ROWS{20'h71234}};
        i_first_ic = 1'b1;
        i_last_ic = 1'b1;
      end
      if (m_axis_tvalid && !seen) begin
        seen = 1;
        chk("first_latency", waited <= 3, 1);
      end
      m_axis_tready = use_pat ? pat[cyc % 4] : 1'b1;
      if (seen) cyc++;
      if (m_axis_tvalid && m_axis_tready) begin
        expv = exp_q.pop_front();
        got++;
        chk("beat", {m_axis_tlast, m_axis_tdata}, expv);
        if (exp_q.size() == 0 || got == stop_after) begin
          i_psum_valid = 1'b0;
          break;
        end
      end else if (m_axis_tvalid) begin
        stalled = 1;
        hold = {m_axis_tlast, m_axis_tdata};
      end
    end
    i_psum_valid = 1'b0;
    m_axis_tready = 1'b1;
    if (stop_after == 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_ready"}, o_psum_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_psum_ready, 1);
    chk("tstrb", m_axis_tstrb, 4'hf);

    // single channel, lanes 5, bias from reset (0)
    run_channel(5, 0, 1, 1);
    push_expected(0);
    drain(0, 0, 0);
    post_idle("single");

    // two channels with a bias pulse in ACCUM that must be ignored
    load_bias(-10);
    run_channel(100, 0, 1, 0);
    chk("accum_busy", o_busy, 1);
    load_bias(50);
    run_channel(30, 0, 0, 1);
    push_expected(-10);
    drain(0, 0, 0);
    post_idle("two_ch");

    load_bias(20);
    run_channel(-50, 0, 1, 1);
    push_expected(20);
    drain(0, 0, 0);

    load_bias(0);
    run_channel(300, 0, 1, 1);
    push_expected(0);
    drain(0, 0, 0);

    run_channel(524287, 0, 1, 0);
    run_channel(524287, 0, 0, 1);
    push_expected(0);
    drain(0, 0, 0);

    // saturated accumulator then pulled back down: 524287 - 524200 = 87
    run_channel(524287, 0, 1, 0);
    run_channel(524287, 0, 0, 0);
    run_channel(-524200, 0, 0, 1);
    push_expected(0);
    drain(0, 0, 0);

    // distinct per-pixel values, back-pressure, psum offered during drain
    load_bias(3);
    run_channel(-5, 7, 1, 1);
    push_expected(3);
    drain(1, 0, 1);
    post_idle("stall");

    // abort after the first beat, then a clean rerun with bias cleared by reset
    load_bias(7);
    run_channel(5, 0, 1, 1);
    push_expected(7);
    drain(0, 1, 0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", m_axis_tvalid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_ready", o_psum_ready, 1);
    chk("abort_tlast", m_axis_tlast, 0);
    rstn = 1'b1;
    exp_q.delete();
    run_channel(5, 0, 1, 1);
    push_expected(0);
    drain(0, 0, 0);
    post_idle("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
